// File: rtl/fifo_mem_ctrl.sv
// fifo_mem_ctrl: valid/ready byte FIFO over a single-port 8-bit memory, plus a one-entry pop register; push-to-pop 3 cycles.
// push_ready drops when full or when a read owns the port; FIFO_MEM_CTRL_BYPASS_EN sends pushes into an empty FIFO straight to the pop register.
module fifo_mem_ctrl #(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_valid,
  input  logic [7:0] push_data,
  output logic       push_ready,
  output logic       pop_valid,
  output logic [7:0] pop_data,
  input  logic       pop_ready,
  output logic [7:0] addr,
  output logic       wr_en,
  output logic       rd_en,
  output logic [7:0] wdata,
  input  logic [7:0] rdata,
  output logic       full,
  output logic       empty,
  output logic [8:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [8:0]    mem_cnt;
  logic          rd_pend;

  logic pop_fire;
  logic rd_go;
  logic push_fire;
  logic bypass_go;
  logic mem_wr;

  assign pop_fire   = pop_valid && pop_ready;
  // Reads win the single port; nothing is issued while reset is held.
  assign rd_go      = reset && (mem_cnt != 9'd0) && !rd_pend && (!pop_valid || pop_fire);
  assign full       = (mem_cnt == 9'(DEPTH));
  assign push_ready = reset && !full && !rd_go;
  assign push_fire  = push_valid && push_ready;

`ifdef FIFO_MEM_CTRL_BYPASS_EN
  assign bypass_go  = push_fire && (mem_cnt == 9'd0) && !rd_pend && (!pop_valid || pop_fire);
`else
  assign bypass_go  = 1'b0;
`endif

  assign mem_wr = push_fire && !bypass_go;

  assign empty = (mem_cnt == 9'd0) && !rd_pend && !pop_valid;
  assign level = mem_cnt + 9'(rd_pend) + 9'(pop_valid);

  always_comb begin
    addr  = 8'd0;
    wdata = 8'd0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (rd_go) begin
      rd_en = 1'b1;
      addr  = 8'(rd_ptr);
    end else if (mem_wr) begin
      wr_en = 1'b1;
      addr  = 8'(wr_ptr);
      wdata = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= 9'd0;
      rd_pend   <= 1'b0;
      pop_valid <= 1'b0;
      pop_data  <= 8'd0;
    end else begin
      if (mem_wr) begin
        wr_ptr  <= wr_ptr + 1'b1;
        mem_cnt <= mem_cnt + 9'd1;
      end else if (rd_go) begin
        mem_cnt <= mem_cnt - 9'd1;
      end
      if (rd_go) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      rd_pend <= rd_go;
      // A read is only issued when the pop register will be free on arrival.
      if (rd_pend) begin
        pop_data  <= rdata;
        pop_valid <= 1'b1;
      end else if (bypass_go) begin
        pop_data  <= push_data;
        pop_valid <= 1'b1;
      end else if (pop_fire) begin
        pop_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Bench for fifo_mem_ctrl: directed steps on a DEPTH=256 instance, wrap and random traffic on a DEPTH=4 instance.
module tb_fifo_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       push_valid, push_ready, pop_valid, pop_ready, wr_en, rd_en, full, empty;
  logic [7:0] push_data, pop_data, addr, wdata, rdata;
  logic [8:0] level;

  logic       s_push_valid, s_push_ready, s_pop_valid, s_pop_ready, s_wr_en, s_rd_en, s_full, s_empty;
  logic [7:0] s_push_data, s_pop_data, s_addr, s_wdata, s_rdata;
  logic [8:0] s_level;

  logic [7:0] mem   [256];
  logic [7:0] s_mem [4];

  fifo_mem_ctrl #(.DEPTH(256)) u_dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
    .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata), .rdata(rdata),
    .full(full), .empty(empty), .level(level)
  );

  fifo_mem_ctrl #(.DEPTH(4)) u_small (
    .clk(clk), .reset(reset),
    .push_valid(s_push_valid), .push_data(s_push_data), .push_ready(s_push_ready),
    .pop_valid(s_pop_valid), .pop_data(s_pop_data), .pop_ready(s_pop_ready),
    .addr(s_addr), .wr_en(s_wr_en), .rd_en(s_rd_en), .wdata(s_wdata), .rdata(s_rdata),
    .full(s_full), .empty(s_empty), .level(s_level)
  );

  // Single-port memory models: read data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
    if (rd_en) rdata <= mem[addr];
  end

  always @(posedge clk) begin
    if (s_wr_en) s_mem[s_addr[1:0]] <= s_wdata;
    if (s_rd_en) s_rdata <= s_mem[s_addr[1:0]];
  end

  int checks   = 0;
  int failures = 0;

  logic [7:0] sq[$];
  int wr_k, rd_k, run, s_pops, s_pushes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_main(input logic [7:0] d);
    int w;
    w = 0;
    push_valid = 1'b1;
    push_data  = d;
    @(negedge clk);
    while (!push_ready && w < 8) begin
      tick();
      @(negedge clk);
      w++;
    end
    chk("push_accept", push_ready, 1);
    chk("push_one_port", wr_en && rd_en, 0);
    tick();
    push_valid = 1'b0;
  endtask

  task automatic drain_main(input logic [7:0] first, input int n);
    int got, cyc;
    logic [7:0] e;
    got = 0;
    cyc = 0;
    e   = first;
    pop_ready = 1'b1;
    while (got < n && cyc < 4 * n + 10) begin
      @(negedge clk);
      chk("drain_one_port", wr_en && rd_en, 0);
      if (pop_valid) begin
        chk("drain_data", pop_data, e);
        e++;
        got++;
      end
      tick();
      cyc++;
    end
    pop_ready = 1'b0;
    chk("drain_count", got, n);
  endtask

  // Reference model for the small instance: the FIFO contents as a queue, writes/reads walk addresses modulo 4.
  task automatic s_cycle();
    int sz;
    @(negedge clk);
    sz = sq.size();
    chk("s_level", s_level, sz);
    chk("s_empty", s_empty, (sz == 0));
    chk("s_one_port", s_wr_en && s_rd_en, 0);
    chk("s_addr_hi", s_addr[7:2], 0);
    if (sz == 5) chk("s_cap", {s_full, s_push_ready}, 2'b10);
    if (s_full) chk("s_full_lvl", s_level >= 9'd4, 1);
    if (!s_rd_en && sz < 4) chk("s_ready", s_push_ready, 1);
    if (s_wr_en) begin
      chk("s_waddr", s_addr, wr_k % 4);
      chk("s_wdata", s_wdata, s_push_data);
      chk("s_wr_hs", s_push_valid && s_push_ready, 1);
      wr_k++;
    end
`ifndef FIFO_MEM_CTRL_BYPASS_EN
    chk("s_wr_fire", s_wr_en, s_push_valid && s_push_ready);
`endif
    if (s_rd_en) begin
      chk("s_raddr", s_addr, rd_k % 4);
      rd_k++;
    end
    if (!s_wr_en && !s_rd_en) chk("s_idle", {s_addr, s_wdata}, 16'h0000);
    if (sz > 0 && !s_pop_valid) run++;
    else run = 0;
    chk("s_pop_lat", run <= 2, 1);
    if (s_pop_valid && s_pop_ready) begin
      if (sz == 0) chk("s_pop_nodata", s_pop_valid, 0);
      else begin
        chk("s_pop_data", s_pop_data, sq[0]);
        void'(sq.pop_front());
        s_pops++;
      end
    end
    if (s_push_valid && s_push_ready) begin
      sq.push_back(s_push_data);
      s_pushes++;
    end
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b0;
    push_valid = 1'b0; push_data = 8'h00; pop_ready = 1'b0;
    s_push_valid = 1'b0; s_push_data = 8'h00; s_pop_ready = 1'b0;
    repeat (2) tick();

    // Reset state; a push offered during reset must be refused.
    push_valid = 1'b1; push_data = 8'h5A;
    @(negedge clk);
    chk("rst_push_ready", push_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_pop_data", pop_data, 0);
    tick();
    push_valid = 1'b0;
    reset = 1'b1;

    // Single byte into an empty FIFO.
`ifdef FIFO_MEM_CTRL_BYPASS_EN
    push_valid = 1'b1; push_data = 8'h3C;
    @(negedge clk);
    chk("bp_push_ready", push_ready, 1);
    chk("bp_c0_wr_en", wr_en, 0);
    chk("bp_c0_level", level, 0);
    tick();
    push_valid = 1'b0;
    @(negedge clk);
    chk("bp_pop_valid", pop_valid, 1);
    chk("bp_pop_data", pop_data, 8'h3C);
    chk("bp_c1_wr_en", wr_en, 0);
    chk("bp_c1_level", level, 1);
    tick();
    drain_main(8'h3C, 1);
`else
    push_valid = 1'b1; push_data = 8'hA5;
    @(negedge clk);
    chk("c0_wr_en", wr_en, 1);
    chk("c0_addr", addr, 0);
    chk("c0_wdata", wdata, 8'hA5);
    chk("c0_rd_en", rd_en, 0);
    chk("c0_level", level, 0);
    tick();
    push_valid = 1'b0;
    @(negedge clk);
    chk("c1_rd_en", rd_en, 1);
    chk("c1_addr", addr, 0);
    chk("c1_wr_en", wr_en, 0);
    chk("c1_level", level, 1);
    tick();
    @(negedge clk);
    chk("c2_pop_valid", pop_valid, 0);
    chk("c2_level", level, 1);
    tick();
    @(negedge clk);
    chk("c3_pop_valid", pop_valid, 1);
    chk("c3_pop_data", pop_data, 8'hA5);
    chk("c3_level", level, 1);
    tick();
    drain_main(8'hA5, 1);
`endif
    @(negedge clk);
    chk("single_empty", empty, 1);
    chk("single_level", level, 0);
    tick();

    // Fill: one byte in the pop register plus 256 in memory.
    for (int i = 0; i < 257; i++) push_main(8'(i));
    repeat (2) tick();
    push_valid = 1'b1; push_data = 8'hEE;
    @(negedge clk);
    chk("fill_full", full, 1);
    chk("fill_level", level, 257);
    chk("fill_push_ready", push_ready, 0);
    chk("fill_wr_en", wr_en, 0);
    tick();
    push_valid = 1'b0;
    drain_main(8'h00, 257);
    @(negedge clk);
    chk("drain_empty", empty, 1);
    chk("drain_level", level, 0);
    chk("drain_full", full, 0);
    tick();

    // Contention: push held while popping with data still in memory.
    push_main(8'h50); push_main(8'h51); push_main(8'h52);
    w = 0;
    @(negedge clk);
    while (!pop_valid && w < 8) begin
      tick();
      @(negedge clk);
      w++;
    end
    tick();
    push_valid = 1'b1; push_data = 8'h53; pop_ready = 1'b1;
    @(negedge clk);
    chk("ct_pop_data", pop_data, 8'h50);
    chk("ct_rd_en", rd_en, 1);
    chk("ct_push_ready", push_ready, 0);
    chk("ct_wr_en", wr_en, 0);
    tick();
    pop_ready = 1'b0;
    @(negedge clk);
    chk("ct2_push_ready", push_ready, 1);
    chk("ct2_wr_en", wr_en, 1);
    chk("ct2_wdata", wdata, 8'h53);
    chk("ct2_rd_en", rd_en, 0);
    tick();
    push_valid = 1'b0;
    drain_main(8'h51, 3);

    // Reset asserted in the cycle after a read is issued.
    push_main(8'h77); push_main(8'h78);
    pop_ready = 1'b1;
    @(negedge clk);
    chk("rm_rd_en", rd_en, 1);
    tick();
    reset = 1'b0;
    pop_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("rm_pop_valid", pop_valid, 0);
    chk("rm_empty", empty, 1);
    chk("rm_level", level, 0);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rm_after_pop_valid", pop_valid, 0);
    chk("rm_after_level", level, 0);
    tick();

    // Wrap on DEPTH=4: ten bytes through with pop always ready.
    sq.delete();
    wr_k = 0; rd_k = 0; run = 0; s_pops = 0; s_pushes = 0;
    s_pop_ready = 1'b1;
    for (int c = 0; c < 100 && s_pops < 10; c++) begin
      s_push_valid = (s_pushes < 10);
      s_push_data  = 8'h10 + 8'(s_pushes);
      s_cycle();
    end
    s_push_valid = 1'b0;
    chk("wrap_pops", s_pops, 10);
`ifndef FIFO_MEM_CTRL_BYPASS_EN
    chk("wrap_writes", wr_k, 10);
`endif

    // Random traffic in phases of drain-heavy, fill-heavy and balanced pops.
    for (int c = 0; c < 1500; c++) begin
      int ph;
      ph = (c / 250) % 3;
      s_push_valid = ($urandom_range(99) < 70);
      s_push_data  = 8'($urandom);
      s_pop_ready  = ($urandom_range(99) < ((ph == 0) ? 80 : (ph == 1) ? 15 : 50));
      s_cycle();
    end
    s_push_valid = 1'b0;
    s_pop_ready  = 1'b1;
    repeat (20) s_cycle();
    chk("s_final_empty", s_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
